// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two data-memory requesters (A: CPU, B: debug/loader),
// the arbiter and the data memory. The arbiter binds the slave modport.
interface dmem_port_arbiter_if;
  // Handshake: a requester raises req with its payload and holds both until gnt.
  // gnt is same-cycle acceptance. rvalid/q follow exactly one cycle after a read gnt.
  logic        a_req;
  logic        a_wren;
  logic [31:0] a_address;
  logic [1:0]  a_mem_mode;
  logic        a_unsigned;
  logic [31:0] a_data;
  logic        a_gnt;
  logic        a_rvalid;
  logic [31:0] a_q;

  logic        b_req;
  logic        b_wren;
  logic [31:0] b_address;
  logic [1:0]  b_mem_mode;
  logic        b_unsigned;
  logic [31:0] b_data;
  logic        b_lock;
  logic        b_gnt;
  logic        b_rvalid;
  logic [31:0] b_q;

  logic [31:0] mem_address;
  logic [1:0]  mem_mode;
  logic        mem_unsigned;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;

  logic [1:0]  arb_state;

  modport slave (
    input  a_req, a_wren, a_address, a_mem_mode, a_unsigned, a_data,
    output a_gnt, a_rvalid, a_q,
    input  b_req, b_wren, b_address, b_mem_mode, b_unsigned, b_data, b_lock,
    output b_gnt, b_rvalid, b_q,
    output mem_address, mem_mode, mem_unsigned, mem_data, mem_wren,
    input  mem_q,
    output arb_state
  );

  modport master (
    output a_req, a_wren, a_address, a_mem_mode, a_unsigned, a_data,
    input  a_gnt, a_rvalid, a_q,
    output b_req, b_wren, b_address, b_mem_mode, b_unsigned, b_data, b_lock,
    input  b_gnt, b_rvalid, b_q,
    input  mem_address, mem_mode, mem_unsigned, mem_data, mem_wren,
    output mem_q,
    input  arb_state
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for the shared data-memory port with B starvation guard and B lock bursts.
// Define DMEM_ARB_ROUND_ROBIN_EN to resolve plain A/B ties round-robin instead of A-first.
module dmem_port_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int BURST_MAX    = 4
) (
  input  logic               clock,
  input  logic               reset,
  dmem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, LOCK_B} state_t;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);
  localparam logic [4:0] BURST_LIM  = 5'(BURST_MAX);

  state_t      state;
  logic [7:0]  starve_cnt;
  logic [3:0]  burst_cnt;
  logic        rd_pending;
  logic        rd_owner_b;
  logic        rd_unsigned;
  logic [31:0] hold_address;
  logic [31:0] hold_data;
  logic [1:0]  hold_mode;

  logic        gnt_a;
  logic        gnt_b;
  logic        tie_to_a;
  logic [3:0]  burst_next;
  logic        lock_keep;

  logic [31:0] mem_address_c;
  logic [31:0] mem_data_c;
  logic [1:0]  mem_mode_c;
  logic        mem_wren_c;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_grant_b;

  // Reset to B so that A takes the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_b <= 1'b1;
    end else if (gnt_a || gnt_b) begin
      last_grant_b <= gnt_b;
    end
  end

  assign tie_to_a = last_grant_b;
`else
  assign tie_to_a = 1'b1;
`endif

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!reset) begin
      if (bus.b_req && (state == LOCK_B || starve_cnt >= STARVE_LIM)) begin
        gnt_b = 1'b1;
      end else if (bus.a_req && bus.b_req) begin
        gnt_a = tie_to_a;
        gnt_b = !tie_to_a;
      end else if (bus.a_req) begin
        gnt_a = 1'b1;
      end else if (bus.b_req) begin
        gnt_b = 1'b1;
      end
    end
  end

  // burst_next is the lock-burst count including a B grant made this cycle minus one,
  // so a fresh burst of BURST_MAX grants ends with the last grant landing in OWN_B.
  assign burst_next = (state == LOCK_B) ? burst_cnt + 4'd1 : 4'd0;
  assign lock_keep  = bus.b_lock && (({1'b0, burst_next} + 5'd1) < BURST_LIM);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      starve_cnt   <= 8'd0;
      burst_cnt    <= 4'd0;
      rd_pending   <= 1'b0;
      rd_owner_b   <= 1'b0;
      rd_unsigned  <= 1'b0;
      hold_address <= 32'd0;
      hold_data    <= 32'd0;
      hold_mode    <= 2'd0;
    end else begin
      if (gnt_b) begin
        state <= lock_keep ? LOCK_B : OWN_B;
      end else if (gnt_a) begin
        state <= OWN_A;
      end else begin
        state <= IDLE;
      end

      burst_cnt <= gnt_b ? burst_next : 4'd0;

      if (bus.b_req && !gnt_b) begin
        starve_cnt <= (starve_cnt == 8'hFF) ? starve_cnt : starve_cnt + 8'd1;
      end else begin
        starve_cnt <= 8'd0;
      end

      rd_pending  <= (gnt_a && !bus.a_wren) || (gnt_b && !bus.b_wren);
      rd_owner_b  <= gnt_b;
      rd_unsigned <= gnt_b ? bus.b_unsigned : bus.a_unsigned;

      if (gnt_a) begin
        hold_address <= bus.a_address;
        hold_data    <= bus.a_data;
        hold_mode    <= bus.a_mem_mode;
      end else if (gnt_b) begin
        hold_address <= bus.b_address;
        hold_data    <= bus.b_data;
        hold_mode    <= bus.b_mem_mode;
      end
    end
  end

  always_comb begin
    mem_address_c = hold_address;
    mem_data_c    = hold_data;
    mem_mode_c    = hold_mode;
    mem_wren_c    = 1'b0;
    if (gnt_a) begin
      mem_address_c = bus.a_address;
      mem_data_c    = bus.a_data;
      mem_mode_c    = bus.a_mem_mode;
      mem_wren_c    = bus.a_wren;
    end else if (gnt_b) begin
      mem_address_c = bus.b_address;
      mem_data_c    = bus.b_data;
      mem_mode_c    = bus.b_mem_mode;
      mem_wren_c    = bus.b_wren;
    end
    if (reset) begin
      mem_address_c = 32'd0;
      mem_data_c    = 32'd0;
      mem_mode_c    = 2'd0;
      mem_wren_c    = 1'b0;
    end
  end

  assign bus.a_gnt       = gnt_a;
  assign bus.b_gnt       = gnt_b;
  assign bus.mem_address = mem_address_c;
  assign bus.mem_data    = mem_data_c;
  assign bus.mem_mode    = mem_mode_c;
  assign bus.mem_wren    = mem_wren_c;

  // The memory sign-extends in the response cycle, so the flag follows the pending read.
  assign bus.mem_unsigned = !reset && rd_pending && rd_unsigned;
  assign bus.a_rvalid     = !reset && rd_pending && !rd_owner_b;
  assign bus.b_rvalid     = !reset && rd_pending && rd_owner_b;
  assign bus.a_q          = bus.a_rvalid ? bus.mem_q : 32'd0;
  assign bus.b_q          = bus.b_rvalid ? bus.mem_q : 32'd0;
  assign bus.arb_state    = state;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus random traffic against a
// grant/response reference model. Honors DMEM_ARB_ROUND_ROBIN_EN like the design.
module tb_dmem_port_arbiter;
  localparam int STARVE_LIMIT = 8;
  localparam int BURST_MAX    = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dmem_port_arbiter_if bus();

  dmem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .BURST_MAX(BURST_MAX)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_errors = 0;

  // Outstanding read responses: {unsigned, owner_is_b, data the memory will return}
  logic [33:0] exp_q[$];
  bit          m_lock;
  int          m_burst;
  int          m_starve;
  bit          m_last_b;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic [1:0]  m_mode;
  bit          m_ga;
  bit          m_gb;

  logic        obs_a_gnt, obs_b_gnt, obs_a_rvalid, obs_b_rvalid, obs_mem_uns, obs_mem_wren;
  logic [31:0] obs_a_q, obs_b_q, obs_mem_address, obs_mem_q_drv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_lock   = 1'b0;
    m_burst  = 0;
    m_starve = 0;
    m_last_b = 1'b1;
    m_addr   = 32'd0;
    m_data   = 32'd0;
    m_mode   = 2'd0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.a_req = 1'b0; bus.a_wren = 1'b0; bus.a_address = 32'd0; bus.a_mem_mode = 2'd0;
    bus.a_unsigned = 1'b0; bus.a_data = 32'd0;
    bus.b_req = 1'b0; bus.b_wren = 1'b0; bus.b_address = 32'd0; bus.b_mem_mode = 2'd0;
    bus.b_unsigned = 1'b0; bus.b_data = 32'd0; bus.b_lock = 1'b0;
    bus.mem_q = 32'd0;
  endtask

  task automatic new_a();
    bus.a_wren     = 1'($urandom_range(0, 1));
    bus.a_address  = $urandom;
    bus.a_mem_mode = 2'($urandom_range(0, 3));
    bus.a_unsigned = 1'($urandom_range(0, 1));
    bus.a_data     = $urandom;
  endtask

  task automatic new_b();
    bus.b_wren     = 1'($urandom_range(0, 1));
    bus.b_address  = $urandom;
    bus.b_mem_mode = 2'($urandom_range(0, 3));
    bus.b_unsigned = 1'($urandom_range(0, 1));
    bus.b_data     = $urandom;
  endtask

  // One clock cycle: entered 1 time unit after a rising edge with inputs driven.
  // Plays the memory, predicts and checks all outputs, advances the model.
  task automatic tick();
    logic        resp, resp_b, resp_u, ga, gb, g_wren, g_uns;
    logic [31:0] resp_d, g_addr, g_data, e_addr, e_data, rd_word;
    logic [1:0]  g_mode, e_mode;

    resp   = (exp_q.size() > 0);
    resp_u = 1'b0; resp_b = 1'b0; resp_d = 32'd0;
    if (resp) {resp_u, resp_b, resp_d} = exp_q[0];
    bus.mem_q     = resp ? resp_d : $urandom;
    obs_mem_q_drv = bus.mem_q;

    ga = 1'b0;
    gb = 1'b0;
    if (!reset) begin
      if (bus.b_req && (m_lock || m_starve >= STARVE_LIMIT)) gb = 1'b1;
      else if (bus.a_req && bus.b_req) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        if (m_last_b) ga = 1'b1; else gb = 1'b1;
`else
        ga = 1'b1;
`endif
      end
      else if (bus.a_req) ga = 1'b1;
      else if (bus.b_req) gb = 1'b1;
    end
    g_wren = gb ? bus.b_wren : bus.a_wren;
    g_uns  = gb ? bus.b_unsigned : bus.a_unsigned;
    g_addr = gb ? bus.b_address : bus.a_address;
    g_data = gb ? bus.b_data : bus.a_data;
    g_mode = gb ? bus.b_mem_mode : bus.a_mem_mode;
    e_addr = reset ? 32'd0 : ((ga || gb) ? g_addr : m_addr);
    e_data = reset ? 32'd0 : ((ga || gb) ? g_data : m_data);
    e_mode = reset ? 2'd0 : ((ga || gb) ? g_mode : m_mode);

    #3;
    obs_a_gnt = bus.a_gnt; obs_b_gnt = bus.b_gnt;
    obs_a_rvalid = bus.a_rvalid; obs_b_rvalid = bus.b_rvalid;
    obs_a_q = bus.a_q; obs_b_q = bus.b_q;
    obs_mem_uns = bus.mem_unsigned; obs_mem_wren = bus.mem_wren;
    obs_mem_address = bus.mem_address;

    check("a_gnt", 32'(bus.a_gnt), 32'(ga));
    check("b_gnt", 32'(bus.b_gnt), 32'(gb));
    check("mem_wren", 32'(bus.mem_wren), 32'((ga || gb) && g_wren));
    check("mem_address", bus.mem_address, e_addr);
    check("mem_data", bus.mem_data, e_data);
    check("mem_mode", 32'(bus.mem_mode), 32'(e_mode));
    check("mem_unsigned", 32'(bus.mem_unsigned), 32'(!reset && resp && resp_u));
    check("a_rvalid", 32'(bus.a_rvalid), 32'(!reset && resp && !resp_b));
    check("b_rvalid", 32'(bus.b_rvalid), 32'(!reset && resp && resp_b));
    check("a_q", bus.a_q, (!reset && resp && !resp_b) ? resp_d : 32'd0);
    check("b_q", bus.b_q, (!reset && resp && resp_b) ? resp_d : 32'd0);

    m_ga = ga;
    m_gb = gb;
    if (reset) begin
      model_reset();
    end else begin
      if (resp) void'(exp_q.pop_front());
      if (ga || gb) begin
        m_last_b = gb;
        m_addr   = g_addr;
        m_data   = g_data;
        m_mode   = g_mode;
        if (!g_wren) begin
          rd_word = $urandom;
          exp_q.push_back({g_uns, gb, rd_word});
        end
      end
      if (gb) begin
        m_burst = m_lock ? m_burst + 1 : 1;
        m_lock  = bus.b_lock && (m_burst < BURST_MAX);
      end else begin
        m_burst = 0;
        m_lock  = 1'b0;
      end
      if (bus.b_req && !gb) m_starve = (m_starve < 255) ? m_starve + 1 : 255;
      else m_starve = 0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  bit a_act, b_act;
  int a_prob;
  bit exp_b;

  initial begin
    idle_inputs();
    model_reset();
    @(posedge clock);
    #1;

    // Outputs held at reset values even with both ports requesting.
    bus.a_req = 1'b1; bus.b_req = 1'b1; bus.a_address = 32'h44; bus.b_address = 32'h88;
    tick();
    check("rst_a_gnt", 32'(obs_a_gnt), 32'd0);
    check("rst_b_gnt", 32'(obs_b_gnt), 32'd0);
    check("rst_mem_address", obs_mem_address, 32'd0);

    // Single A read.
    do_reset();
    bus.a_req = 1'b1; bus.a_wren = 1'b0; bus.a_address = 32'h10; bus.a_mem_mode = 2'd2;
    tick();
    check("a_read_gnt", 32'(obs_a_gnt), 32'd1);
    check("a_read_addr", obs_mem_address, 32'h10);
    bus.a_req = 1'b0;
    tick();
    check("a_read_rvalid", 32'(obs_a_rvalid), 32'd1);
    check("a_read_q", obs_a_q, obs_mem_q_drv);
    check("a_read_b_rvalid", 32'(obs_b_rvalid), 32'd0);
    check("a_read_addr_hold", obs_mem_address, 32'h10);

    // Both ports requesting continuously: starvation release (or alternation with round-robin).
    do_reset();
    bus.a_req = 1'b1; bus.a_address = 32'h100;
    bus.b_req = 1'b1; bus.b_address = 32'h200;
    for (int c = 1; c <= 12; c++) begin
      tick();
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      exp_b = (c % 2 == 0);
`else
      exp_b = (c == 9);
`endif
      check($sformatf("hold_b_gnt_c%0d", c), 32'(obs_b_gnt), 32'(exp_b));
      check($sformatf("hold_a_gnt_c%0d", c), 32'(obs_a_gnt), 32'(!exp_b));
    end

    // B lock burst against a continuously requesting A.
    do_reset();
    bus.b_req = 1'b1; bus.b_lock = 1'b1; bus.b_wren = 1'b1; bus.b_address = 32'h300;
    tick();
    check("lock_b_gnt_c1", 32'(obs_b_gnt), 32'd1);
    bus.a_req = 1'b1; bus.a_address = 32'h400;
    for (int c = 2; c <= 5; c++) begin
      tick();
      check($sformatf("lock_b_gnt_c%0d", c), 32'(obs_b_gnt), 32'(c <= 4));
      check($sformatf("lock_a_gnt_c%0d", c), 32'(obs_a_gnt), 32'(c == 5));
    end

    // Unsigned B byte read followed by a signed A write.
    do_reset();
    bus.b_req = 1'b1; bus.b_wren = 1'b0; bus.b_mem_mode = 2'd0; bus.b_unsigned = 1'b1;
    bus.b_address = 32'h503;
    tick();
    check("uns_b_gnt", 32'(obs_b_gnt), 32'd1);
    bus.b_req = 1'b0;
    bus.a_req = 1'b1; bus.a_wren = 1'b1; bus.a_unsigned = 1'b0; bus.a_data = 32'hCAFE_F00D;
    tick();
    check("uns_mem_unsigned", 32'(obs_mem_uns), 32'd1);
    check("uns_b_rvalid", 32'(obs_b_rvalid), 32'd1);
    check("uns_b_q", obs_b_q, obs_mem_q_drv);
    check("uns_a_rvalid", 32'(obs_a_rvalid), 32'd0);
    check("uns_a_write", 32'(obs_mem_wren), 32'd1);
    bus.a_req = 1'b0;
    tick();
    check("uns_after_write", 32'(obs_mem_uns), 32'd0);
    check("uns_no_a_rvalid", 32'(obs_a_rvalid), 32'd0);

    // Reset while a read is in flight drops the response.
    do_reset();
    bus.a_req = 1'b1; bus.a_wren = 1'b0; bus.a_address = 32'h600;
    tick();
    check("midrst_gnt", 32'(obs_a_gnt), 32'd1);
    bus.a_req = 1'b0;
    reset = 1'b1;
    tick();
    check("midrst_a_rvalid", 32'(obs_a_rvalid), 32'd0);
    check("midrst_addr", obs_mem_address, 32'd0);
    reset = 1'b0;
    tick();
    check("midrst_after_rvalid", 32'(obs_a_rvalid), 32'd0);

    // Random traffic; requesters hold their payload until granted.
    do_reset();
    a_act = 1'b0;
    b_act = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      a_prob = ((i / 250) % 2 == 1) ? 95 : 55;
      if (!a_act && $urandom_range(0, 99) < a_prob) begin a_act = 1'b1; new_a(); end
      if (!b_act && $urandom_range(0, 99) < 50) begin b_act = 1'b1; new_b(); end
      bus.a_req  = a_act;
      bus.b_req  = b_act;
      bus.b_lock = ($urandom_range(0, 99) < 60);
      reset      = ($urandom_range(0, 199) == 0);
      tick();
      if (m_ga) a_act = 1'b0;
      if (m_gb) b_act = 1'b0;
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
